// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative shift-and-add-3 binary-to-BCD converter, one input bit per clkin cycle.
// The bcd output only changes on completion, so downstream display logic never sees partial digits.
`timescale 1ns/1ps
module bin2bcd_seq #(
  parameter int BIN_W      = 16,
  parameter int DIGITS     = 5,
  parameter int AUTO_START = 0
) (
  input  logic                  clkin,
  input  logic                  clrn,
  input  logic [BIN_W-1:0]      bin,
  input  logic                  start,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done
);
  localparam int BW = 4*DIGITS;
  localparam int CW = $clog2(BIN_W+1);
  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BIN_W-1:0] sr_q, sr_d, last_q, last_d;
  logic [BW-1:0]    scr_q, scr_d, bcd_q, bcd_d, adj, shf;
  logic             busy_q, busy_d, done_q, done_d, trig, unused_msb;
  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    assign adj[4*k+:4] = (scr_q[4*k+:4] >= 4'd5) ? scr_q[4*k+:4] + 4'd3 : scr_q[4*k+:4];
  end
  // The top scratch bit is always shifted out; it stays zero while 10^DIGITS > 2^BIN_W-1.
  assign shf        = {adj[BW-2:0], sr_q[BIN_W-1]};
  assign unused_msb = adj[BW-1];
  assign trig       = start || ((AUTO_START != 0) && (bin != last_q));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    last_d  = last_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (trig) begin
        state_d = CONV;
        sr_d    = bin;
        last_d  = bin;
        scr_d   = '0;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
      CONV: begin
        scr_d = shf;
        sr_d  = {sr_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(BIN_W-1)) begin
          bcd_d   = shf;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clkin or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      last_q  <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      last_q  <= last_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign bcd  = bcd_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double-dabble), one bit per clkin cycle.
- Sits between the multiplier product output (16-bit binary p) and the digit scan/7-segment stage (20-bit p_BCD).
- Replaces per-digit divide/modulo logic with a small iterative datapath.
- Holds the last result stable on bcd so the display never shows partial values.

Parameters:
- BIN_W, 16, binary input width; must satisfy 10^DIGITS > 2^BIN_W - 1.
- DIGITS, 5, number of BCD digits produced.
- AUTO_START, 0:
  - 0: conversion begins only on start.
  - 1: the block also self-starts whenever bin differs from the last converted value.

Ports:
- clkin  input  1  conversion clock, rising-edge.
- clrn  input  1  reset.
- bin  input  BIN_W  unsigned binary value to convert (e.g. product p).
- start  input  1  request conversion; sampled only while idle.
- bcd  output  4*DIGITS  packed BCD result; digit k at bits [4k+3:4k], digit 0 = units.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse when bcd has just been updated.

Behaviour:
- Reset: clrn is asynchronous, active-low; clock is clkin.
- Reset values: bcd=0, busy=0, done=0, state=IDLE, bit counter=0, internal last-value register=0, scratch registers=0.
- States: IDLE, CONV.
- IDLE:
  - done is cleared on every edge unless being set.
  - Trigger = start, or (AUTO_START=1 and bin != last-value).
  - On a clkin edge with trigger=1: capture bin into shift register sr, copy bin into last-value, clear BCD scratch, counter=0, busy<=1, go CONV.
- CONV, each edge:
  - Every scratch digit >=5 gets +3.
  - Then {scratch, sr} shift left by one; sr MSB enters scratch bit 0.
  - counter increments.
- On the BIN_W-th CONV edge:
  - bcd<=final scratch, done<=1, busy<=0, go IDLE.
- Latency: trigger sampled at edge 0 → bcd valid and done=1 after edge BIN_W (16). done is high exactly one cycle.
- Throughput:
  - A trigger present at the edge following done (state IDLE, done high) is accepted.
  - Back-to-back period is BIN_W+1 cycles.
- start while busy is ignored; no queuing.
- bin changes during CONV do not affect the current conversion (captured copy used).
  - With AUTO_START=1, a change is picked up at the first IDLE edge after done.
  - With AUTO_START=0, it is ignored until the next start.
- bcd changes only on the completion edge or reset; it is held otherwise.
- Digit adjust applies per nibble independently; no carry between nibbles beyond the shift.
- With the parameter constraint satisfied, the top digit never exceeds 9 (16-bit: top digit ≤6). No overflow flag.
- Reset mid-conversion: immediate abort, all outputs and state to reset values; no done pulse for the aborted conversion.
- AUTO_START after reset: bin=0 does not trigger (matches last-value=0, bcd already 0). Any nonzero bin triggers on the first edge after clrn deasserts.
- Every reachable state and counter value is defined. An illegal state encoding returns to IDLE with busy=0.

Test Plan:
- Reset with clrn=0 during clocking → bcd=0x00000, busy=0, done=0. Release, start=1 one cycle with bin=12345 → busy=1 for 16 cycles; done pulses once after edge 16; bcd=0x12345.
- bin=65535, start → bcd=0x65535. bin=0, start → bcd=0x00000 after 16 cycles with a done pulse. bin=65025 (255×255) → bcd=0x65025. bin=9 → 0x00009. bin=10 → 0x00010.
- Start with bin=4321; at cycle 5 set bin=9999 and pulse start again (AUTO_START=0) → single done; bcd=0x04321. bcd holds 0x04321 until a new start.
- Start bin=5000; assert clrn=0 at cycle 8 → outputs zero immediately; no done. After release, start bin=777 → bcd=0x00777 after 16 cycles.
- AUTO_START=1: after reset bin=0 → no conversion. Set bin=100 → busy next edge; bcd=0x00100. Change bin to 200 mid-conversion → second conversion starts the edge after done; bcd=0x00200. Hold bin constant → no further done pulses.
- Back-to-back: hold start=1 continuously with bin=42 → done pulses every 17 cycles; bcd stays 0x00042 throughout.
